// File: rtl/mant_div_if.sv
// Handshake and operand/result bundle for the iterative mantissa divider.
interface mant_div_if #(
  parameter int MANT_W     = 24,
  parameter int EXTRA_BITS = 2
);
  localparam int N = MANT_W + EXTRA_BITS;

  logic              in_start;
  logic              in_kill;
  logic [MANT_W-1:0] in_dividend;
  logic [MANT_W-1:0] in_divisor;
  logic              out_busy;
  logic              out_valid;
  logic [N-1:0]      out_quot;
  logic              out_sticky;
  logic              out_div_by_zero;

  // Requester side (FP pipeline / testbench)
  modport master (
    output in_start, in_kill, in_dividend, in_divisor,
    input  out_busy, out_valid, out_quot, out_sticky, out_div_by_zero
  );

  // Divider side
  modport slave (
    input  in_start, in_kill, in_dividend, in_divisor,
    output out_busy, out_valid, out_quot, out_sticky, out_div_by_zero
  );
endinterface

// File: rtl/mant_div_iter.sv
// Radix-2 restoring mantissa divider with counter-driven sequencer.
// One quotient bit per cycle, MSB first; N = MANT_W + EXTRA_BITS iterations.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on accepted start
// ITER  | one restoring-division step per cycle, busy asserted
// DONE  | one cycle; result registered to outputs, may accept next start
module mant_div_iter #(
  parameter int MANT_W     = 24,
  parameter int EXTRA_BITS = 2
) (
  input  logic       in_Clk,
  input  logic       in_Rst_N,
  mant_div_if.slave  bus
);
  localparam int N     = MANT_W + EXTRA_BITS;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [MANT_W:0]   rem;
  logic [MANT_W-1:0] dvsr;
  logic [N-1:0]      quo;
  logic [CNT_W-1:0]  cnt;
  logic              dbz;

  logic              valid_q;
  logic [N-1:0]      quot_q;
  logic              sticky_q;
  logic              dbz_q;

  logic              accept;
  logic              iter_en;
  logic              done_fire;
  logic              div_zero;
  logic              rem_ge;
  logic [MANT_W-1:0] diff;

  assign div_zero = (bus.in_divisor == '0);
  assign rem_ge   = (rem >= {1'b0, dvsr});
  // When rem >= dvsr the true difference is below dvsr, so the low MANT_W
  // bits of the subtraction are exact and the shifted value still fits.
  assign diff     = rem[MANT_W-1:0] - dvsr;

  // State register
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state and control strobes; kill overrides everything, including start
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    iter_en   = 1'b0;
    done_fire = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? DONE : ITER;
        end
      end
      ITER: begin
        iter_en = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        done_fire = 1'b1;
        if (bus.in_start) begin
          accept    = 1'b1;
          state_nxt = div_zero ? DONE : ITER;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.in_kill) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      iter_en   = 1'b0;
      done_fire = 1'b0;
    end
  end

  // Operand capture and restoring-division datapath
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      rem  <= '0;
      dvsr <= '0;
      quo  <= '0;
      cnt  <= '0;
      dbz  <= 1'b0;
    end else if (accept) begin
      rem  <= {1'b0, bus.in_dividend};
      dvsr <= bus.in_divisor;
      quo  <= '0;
      cnt  <= CNT_W'(N);
      dbz  <= div_zero;
    end else if (iter_en) begin
      rem  <= rem_ge ? {diff, 1'b0} : {rem[MANT_W-1:0], 1'b0};
      quo  <= {quo[N-2:0], rem_ge};
      cnt  <= cnt - CNT_W'(1);
    end
  end

  // Result registers: updated only when DONE completes, held otherwise
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      valid_q  <= 1'b0;
      quot_q   <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      valid_q <= done_fire;
      if (done_fire) begin
        quot_q   <= dbz ? '1 : quo;
        sticky_q <= dbz ? 1'b0 : (rem != '0);
        dbz_q    <= dbz;
      end
    end
  end

  assign bus.out_busy        = (state == ITER);
  assign bus.out_valid       = valid_q;
  assign bus.out_quot        = quot_q;
  assign bus.out_sticky      = sticky_q;
  assign bus.out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_mant_div_iter.sv
// Self-checking bench for mant_div_iter at MANT_W=24 and MANT_W=53.
module tb_mant_div_iter;
  localparam int N24 = 26;
  localparam int N53 = 55;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [N24-1:0] last_q;
  logic           last_s;

  mant_div_if #(.MANT_W(24), .EXTRA_BITS(2)) if24 ();
  mant_div_if #(.MANT_W(53), .EXTRA_BITS(2)) if53 ();

  mant_div_iter #(.MANT_W(24), .EXTRA_BITS(2)) dut24 (.in_Clk(clk), .in_Rst_N(rst_n), .bus(if24));
  mant_div_iter #(.MANT_W(53), .EXTRA_BITS(2)) dut53 (.in_Clk(clk), .in_Rst_N(rst_n), .bus(if53));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Q = floor(a * 2^(N-1) / b), sticky = remainder non-zero
  function automatic logic [127:0] model_q(input logic [127:0] a, input logic [127:0] b, input int sh);
    return (a << sh) / b;
  endfunction

  function automatic logic model_s(input logic [127:0] a, input logic [127:0] b, input int sh);
    return ((a << sh) % b) != 0;
  endfunction

  task automatic do_div24(input logic [23:0] a, input logic [23:0] b, input string nm);
    logic [N24-1:0] eq;
    logic es, edbz;
    int elat, cyc, bcyc;
    if (b == 0) begin
      eq = '1; es = 1'b0; edbz = 1'b1; elat = 1;
    end else begin
      eq = N24'(model_q(128'(a), 128'(b), N24 - 1));
      es = model_s(128'(a), 128'(b), N24 - 1);
      edbz = 1'b0; elat = N24 + 1;
    end
    @(negedge clk);
    if24.in_start = 1'b1; if24.in_dividend = a; if24.in_divisor = b;
    @(negedge clk);
    if24.in_start = 1'b0;
    cyc = 0; bcyc = 0;
    while (cyc < 200 && !if24.out_valid) begin
      if (if24.out_busy) bcyc++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== elat) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, elat); end
    vectors++;
    if (bcyc !== elat - 1) begin miscompares++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, bcyc, elat - 1); end
    vectors++;
    if (if24.out_quot !== eq) begin miscompares++; $display("FAIL %s quot: got %h expected %h", nm, if24.out_quot, eq); end
    vectors++;
    if (if24.out_sticky !== es) begin miscompares++; $display("FAIL %s sticky: got %b expected %b", nm, if24.out_sticky, es); end
    vectors++;
    if (if24.out_div_by_zero !== edbz) begin miscompares++; $display("FAIL %s dbz: got %b expected %b", nm, if24.out_div_by_zero, edbz); end
    last_q = eq; last_s = es;
    @(negedge clk);
    vectors++;
    if (if24.out_valid !== 1'b0) begin miscompares++; $display("FAIL %s valid_pulse: got %b expected 0", nm, if24.out_valid); end
  endtask

  task automatic do_div53(input logic [52:0] a, input logic [52:0] b, input string nm);
    logic [N53-1:0] eq;
    logic es;
    int cyc, bcyc;
    eq = N53'(model_q(128'(a), 128'(b), N53 - 1));
    es = model_s(128'(a), 128'(b), N53 - 1);
    @(negedge clk);
    if53.in_start = 1'b1; if53.in_dividend = a; if53.in_divisor = b;
    @(negedge clk);
    if53.in_start = 1'b0;
    cyc = 0; bcyc = 0;
    while (cyc < 300 && !if53.out_valid) begin
      if (if53.out_busy) bcyc++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== N53 + 1) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, N53 + 1); end
    vectors++;
    if (bcyc !== N53) begin miscompares++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, bcyc, N53); end
    vectors++;
    if (if53.out_quot !== eq) begin miscompares++; $display("FAIL %s quot: got %h expected %h", nm, if53.out_quot, eq); end
    vectors++;
    if (if53.out_sticky !== es) begin miscompares++; $display("FAIL %s sticky: got %b expected %b", nm, if53.out_sticky, es); end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string nm);
    vectors++;
    if ({if24.out_busy, if24.out_valid, if24.out_quot, if24.out_sticky, if24.out_div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs24: got busy=%b valid=%b quot=%h sticky=%b dbz=%b expected all 0", nm,
               if24.out_busy, if24.out_valid, if24.out_quot, if24.out_sticky, if24.out_div_by_zero);
    end
    vectors++;
    if ({if53.out_busy, if53.out_valid, if53.out_quot, if53.out_sticky, if53.out_div_by_zero} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs53: got busy=%b valid=%b quot=%h expected all 0", nm,
               if53.out_busy, if53.out_valid, if53.out_quot);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_div24(24'hC00000, 24'h800000, "exact");
    vectors++;
    if (if24.out_quot !== 26'h3000000) begin miscompares++; $display("FAIL exact_const quot: got %h expected 3000000", if24.out_quot); end
    do_div24(24'h800000, 24'hC00000, "inexact");
    vectors++;
    if ({if24.out_quot, if24.out_sticky} !== {26'h1555555, 1'b1}) begin
      miscompares++; $display("FAIL inexact_const: got %h/%b expected 1555555/1", if24.out_quot, if24.out_sticky);
    end
    do_div24(24'hFFFFFF, 24'hFFFFFF, "equal");
    vectors++;
    if ({if24.out_quot, if24.out_sticky} !== {26'h2000000, 1'b0}) begin
      miscompares++; $display("FAIL equal_const: got %h/%b expected 2000000/0", if24.out_quot, if24.out_sticky);
    end
  endtask

  task automatic test_random();
    logic [23:0] a, b;
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
      end else begin
        b = 24'($urandom_range(1, 24'hFFFFFF));
        a = 24'({8'd0, $urandom} % (2 * {8'd0, b}));
      end
      do_div24(a, b, "random24");
    end
  endtask

  task automatic test_div_by_zero();
    do_div24(24'h9ABCDE, 24'h000000, "dbz");
    vectors++;
    if (if24.out_quot !== 26'h3FFFFFF) begin miscompares++; $display("FAIL dbz_const quot: got %h expected 3ffffff", if24.out_quot); end
    do_div24(24'hA00000, 24'h800000, "after_dbz");
    vectors++;
    if (if24.out_div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_clear: got %b expected 0", if24.out_div_by_zero); end
  endtask

  task automatic test_kill();
    int vseen;
    do_div24(24'hD00000, 24'h900000, "pre_kill");
    @(negedge clk);
    if24.in_start = 1'b1; if24.in_dividend = 24'h812345; if24.in_divisor = 24'hF00001;
    @(negedge clk);
    if24.in_start = 1'b0;
    repeat (10) @(negedge clk);
    if24.in_kill = 1'b1;
    @(negedge clk);
    if24.in_kill = 1'b0;
    vectors++;
    if (if24.out_busy !== 1'b0) begin miscompares++; $display("FAIL kill_busy: got %b expected 0", if24.out_busy); end
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      if (if24.out_valid) vseen++;
      @(negedge clk);
    end
    vectors++;
    if (vseen !== 0) begin miscompares++; $display("FAIL kill_valid: got %0d pulses expected 0", vseen); end
    vectors++;
    if ({if24.out_quot, if24.out_sticky} !== {last_q, last_s}) begin
      miscompares++; $display("FAIL kill_hold: got %h/%b expected %h/%b", if24.out_quot, if24.out_sticky, last_q, last_s);
    end
    // kill and start together in IDLE: start must be dropped
    if24.in_start = 1'b1; if24.in_kill = 1'b1; if24.in_dividend = 24'hC00000; if24.in_divisor = 24'h800000;
    @(negedge clk);
    if24.in_start = 1'b0; if24.in_kill = 1'b0;
    vseen = 0;
    for (int i = 0; i < 30; i++) begin
      if (if24.out_valid || if24.out_busy) vseen++;
      @(negedge clk);
    end
    vectors++;
    if (vseen !== 0) begin miscompares++; $display("FAIL kill_start: got %0d active cycles expected 0", vseen); end
  endtask

  task automatic test_start_ignored();
    logic [N24-1:0] eq;
    int cyc;
    eq = N24'(model_q(128'(24'hB00000), 128'(24'hE00000), N24 - 1));
    @(negedge clk);
    if24.in_start = 1'b1; if24.in_dividend = 24'hB00000; if24.in_divisor = 24'hE00000;
    @(negedge clk);
    if24.in_start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !if24.out_valid) begin
      if24.in_start = (cyc == 5);
      if (cyc == 5) begin if24.in_dividend = 24'h800001; if24.in_divisor = 24'h800000; end
      @(negedge clk);
      cyc++;
    end
    if24.in_start = 1'b0;
    vectors++;
    if (cyc !== N24 + 1) begin miscompares++; $display("FAIL ignore_start latency: got %0d expected %0d", cyc, N24 + 1); end
    vectors++;
    if (if24.out_quot !== eq) begin miscompares++; $display("FAIL ignore_start quot: got %h expected %h", if24.out_quot, eq); end
    repeat (40) @(negedge clk);
    vectors++;
    if (if24.out_busy !== 1'b0) begin miscompares++; $display("FAIL ignore_start queued: got busy %b expected 0", if24.out_busy); end
  endtask

  task automatic test_back_to_back();
    logic [N24-1:0] qa, qb;
    int cyc;
    bit was_busy;
    qa = N24'(model_q(128'(24'hF00000), 128'(24'h900000), N24 - 1));
    qb = N24'(model_q(128'(24'h876543), 128'(24'hABCDEF), N24 - 1));
    @(negedge clk);
    if24.in_start = 1'b1; if24.in_dividend = 24'hF00000; if24.in_divisor = 24'h900000;
    @(negedge clk);
    if24.in_start = 1'b0;
    cyc = 0; was_busy = 0;
    while (cyc < 200 && !(was_busy && !if24.out_busy)) begin
      if (if24.out_busy) was_busy = 1;
      @(negedge clk);
      cyc++;
    end
    if24.in_start = 1'b1; if24.in_dividend = 24'h876543; if24.in_divisor = 24'hABCDEF;
    @(negedge clk);
    if24.in_start = 1'b0;
    vectors++;
    if ({if24.out_valid, if24.out_quot} !== {1'b1, qa}) begin
      miscompares++; $display("FAIL b2b_first: got valid=%b quot=%h expected 1/%h", if24.out_valid, if24.out_quot, qa);
    end
    vectors++;
    if (if24.out_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b expected 1", if24.out_busy); end
    cyc = 0;
    @(negedge clk); cyc++;
    while (cyc < 200 && !if24.out_valid) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== N24 + 1) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc, N24 + 1); end
    vectors++;
    if (if24.out_quot !== qb) begin miscompares++; $display("FAIL b2b_second quot: got %h expected %h", if24.out_quot, qb); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_div24(24'hE00000, 24'hC00000, "pre_reset");
    @(negedge clk);
    if24.in_start = 1'b1; if24.in_dividend = 24'hC00000; if24.in_divisor = 24'h800000;
    @(negedge clk);
    if24.in_start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    do_div24(24'hC00000, 24'h800000, "after_reset");
  endtask

  task automatic test_wide();
    logic [52:0] a, b;
    do_div53(53'h18000000000000, 53'h10000000000000, "wide_exact");
    vectors++;
    if (if53.out_quot !== (55'd3 << (N53 - 2))) begin
      miscompares++; $display("FAIL wide_const quot: got %h expected %h", if53.out_quot, 55'd3 << (N53 - 2));
    end
    for (int i = 0; i < 4; i++) begin
      a = {1'b1, 20'($urandom), 32'($urandom)};
      b = {1'b1, 20'($urandom), 32'($urandom)};
      do_div53(a, b, "random53");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish expected before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    if24.in_start = 1'b0; if24.in_kill = 1'b0; if24.in_dividend = '0; if24.in_divisor = '0;
    if53.in_start = 1'b0; if53.in_kill = 1'b0; if53.in_dividend = '0; if53.in_divisor = '0;
    test_reset();
    test_directed();
    test_random();
    test_div_by_zero();
    test_kill();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
